hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameters: XLEN, default 32, datapath width; RA_W, default 5, register-address width; FWD_EN, default 1, where 1 enables forwarding and 0 makes the block stall-only; FLUSH_CYC, default 1, legal 1..3, flush cycles per redirect; CNT_W, default 16, performance counter width.
REQ-002 Port clk, input, 1, is the single clock; all state is rising-edge.
REQ-003 Port rst, input, 1, is the reset: asynchronous, active-low.
REQ-004 Port id_valid, input, 1, means the ID stage holds a real instruction.
REQ-005 Ports id_rs1 and id_rs2, input, RA_W each, are the ID source registers; id_use_rs1 and id_use_rs2, input, 1 each, mark each source as actually read.
REQ-006 Ports id_rd (input, RA_W), id_regwrite (input, 1) and id_is_load (input, 1) give the ID destination attributes.
REQ-007 Ports id_rdata1 and id_rdata2, input, XLEN each, are the register-file read data.
REQ-008 Ports ex_fwd_data, mem_fwd_data and wb_fwd_data, input, XLEN each, are the result values in EX, MEM and WB; mem_fwd_data carries load data for loads.
REQ-009 Port ex_redirect, input, 1, means EX resolved a taken branch or jump (pcsrc != 0).
REQ-010 Port stall_if, output, 1, holds the PC and the IF/ID register.
REQ-011 Port flush_id, output, 1, turns the IF/ID contents into a NOP.
REQ-012 Port bubble_ex, output, 1, loads a NOP into ID/EX.
REQ-013 Ports fwd_sel1 and fwd_sel2, output, 2 each, select the operand source: 0 = RF, 1 = EX, 2 = MEM, 3 = WB.
REQ-014 Ports fwd_rdata1 and fwd_rdata2, output, XLEN each, are the resolved operands.
REQ-015 Ports stall_cnt and flush_cnt, output, CNT_W each, are saturating event counters.

Function
REQ-016 The block SHALL keep shadow slots EX, MEM and WB, each holding {valid, rd, regwrite, is_load}, advanced every clock as EX <= (bubble_ex ? 0 : ID attrs & id_valid), MEM <= EX, WB <= MEM.
REQ-017 A slot "matches" source rsN only when: valid=1, regwrite=1, rd==rsN, rd!=0, id_use_rsN=1, id_valid=1.
REQ-018 With FWD_EN=1, operand selection priority SHALL be EX match with is_load=0 > MEM match > WB match > RF; fwd_rdataN = the selected source (combinational, same cycle).
REQ-019 With FWD_EN=1, load-use (EX match with is_load=1) SHALL assert stall_if=1 and bubble_ex=1 for exactly 1 cycle, after which MEM forwarding resolves the operand.
REQ-020 With FWD_EN=0, fwd_sel SHALL always be 0, and any EX, MEM or WB match SHALL stall until no match remains (up to 3 cycles).
REQ-021 The FSM SHALL have states IDLE, STALL and FLUSH; STALL is the registered indication of a stall in progress.
REQ-022 FSM transition: IDLE->FLUSH on ex_redirect.
REQ-023 FSM transition: IDLE->STALL on a hazard without redirect.
REQ-024 FSM transition: STALL->IDLE when the hazard clears.
REQ-025 FSM transition: FLUSH->IDLE after FLUSH_CYC cycles, counted by a flush counter.
REQ-026 The redirect cycle SHALL drive flush_id=1 and bubble_ex=1, and stall_if=0 even if a hazard is present (redirect wins).
REQ-027 In FLUSH, flush_id=1, bubble_ex=1 and stall_if=0 SHALL be held for FLUSH_CYC total cycles including the redirect cycle; hazards are ignored.
REQ-028 A new ex_redirect while in FLUSH SHALL restart the flush count.
REQ-029 stall_cnt SHALL increment once per cycle with stall_if=1 and flush_cnt once per redirect event; both saturate at all-ones without wrapping.
REQ-030 Register x0 SHALL never match, never be forwarded and never cause a stall.

Reset
REQ-031 While rst=0 (asynchronous), all slots SHALL be invalid, FSM=IDLE, flush counter=0, stall_cnt=flush_cnt=0, and outputs forced to stall_if=0, flush_id=0, bubble_ex=0, fwd_sel=0, fwd_rdataN=id_rdataN.
REQ-032 Assertion of rst mid-FLUSH or mid-STALL SHALL abort immediately; after release the first cycle is IDLE with empty slots.

Verification
REQ-033 addi x5 then add x6,x5,x1 back-to-back, FWD_EN=1, ex_fwd_data=0x11 -> fwd_sel1=1, fwd_rdata1=0x11, no stall.
REQ-034 lw x5 then add x6,x5,x0 -> 1 cycle stall_if=1 and bubble_ex=1, then fwd_sel1=2 with mem_fwd_data; stall_cnt=1.
REQ-035 FWD_EN=0, addi x5 then use x5 -> stall_if high 3 cycles, then fwd_sel1=0.
REQ-036 Load-use hazard and ex_redirect in the same cycle, FLUSH_CYC=2 -> stall_if=0, flush_id=1 for 2 cycles, flush_cnt=1.
REQ-037 Writes to x0 followed by a read of x0 -> no stall, fwd_sel=0.
REQ-038 CNT_W=2 with 5 stalls -> stall_cnt=3; rst pulsed low mid-FLUSH -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding-source selection, load-use / no-forward
// stalls, and branch-redirect flushing with saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int FWD_EN    = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_is_load,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  ex_fwd_data,
  input  logic [XLEN-1:0]  mem_fwd_data,
  input  logic [XLEN-1:0]  wb_fwd_data,
  input  logic             ex_redirect,
  output logic             stall_if,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [XLEN-1:0]  fwd_rdata1,
  output logic [XLEN-1:0]  fwd_rdata2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            is_load;
  } slot_t;

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYC - 1);

  slot_t      ex_q, mem_q, wb_q, ex_d;
  state_t     state_q, state_d;
  logic [1:0] fl_cnt_q, fl_cnt_d;
  logic       ex_hit1, mem_hit1, wb_hit1;
  logic       ex_hit2, mem_hit2, wb_hit2;
  logic       hazard, flush_active;
  logic       unused_wb_load;

  function automatic logic hit(input logic valid, input logic regwrite,
                               input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs,
                               input logic use_rs, input logic id_ok);
    return valid && regwrite && (rd == rs) && (rd != '0) && use_rs && id_ok;
  endfunction

  function automatic logic [1:0] pick(input logic ex_h, input logic ex_load,
                                      input logic mem_h, input logic wb_h);
    if (FWD_EN == 0)          return 2'd0;
    if (ex_h && !ex_load)     return 2'd1;
    if (mem_h)                return 2'd2;
    if (wb_h)                 return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [1:0] sel, input logic [XLEN-1:0] rf);
    case (sel)
      2'd1:    return ex_fwd_data;
      2'd2:    return mem_fwd_data;
      2'd3:    return wb_fwd_data;
      default: return rf;
    endcase
  endfunction

  assign ex_hit1  = hit(ex_q.valid,  ex_q.regwrite,  ex_q.rd,  id_rs1, id_use_rs1, id_valid);
  assign mem_hit1 = hit(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rs1, id_use_rs1, id_valid);
  assign wb_hit1  = hit(wb_q.valid,  wb_q.regwrite,  wb_q.rd,  id_rs1, id_use_rs1, id_valid);
  assign ex_hit2  = hit(ex_q.valid,  ex_q.regwrite,  ex_q.rd,  id_rs2, id_use_rs2, id_valid);
  assign mem_hit2 = hit(mem_q.valid, mem_q.regwrite, mem_q.rd, id_rs2, id_use_rs2, id_valid);
  assign wb_hit2  = hit(wb_q.valid,  wb_q.regwrite,  wb_q.rd,  id_rs2, id_use_rs2, id_valid);

  // The WB slot keeps the same layout as EX/MEM; nothing downstream needs its load flag.
  assign unused_wb_load = wb_q.is_load;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hazard = 1'b0;
    if (FWD_EN != 0) hazard = ex_q.is_load && (ex_hit1 || ex_hit2);
    else             hazard = ex_hit1 || mem_hit1 || wb_hit1 || ex_hit2 || mem_hit2 || wb_hit2;
  end

  // Outputs: redirect beats any hazard, and reset forces the quiet pass-through state.
  always_comb begin
    flush_active = rst && (ex_redirect || (state_q == FLUSH));
    flush_id     = flush_active;
    stall_if     = rst && hazard && !flush_active;
    bubble_ex    = flush_active || (rst && hazard);
    fwd_sel1     = rst ? pick(ex_hit1, ex_q.is_load, mem_hit1, wb_hit1) : 2'd0;
    fwd_sel2     = rst ? pick(ex_hit2, ex_q.is_load, mem_hit2, wb_hit2) : 2'd0;
    fwd_rdata1   = operand(fwd_sel1, id_rdata1);
    fwd_rdata2   = operand(fwd_sel2, id_rdata2);
  end

  always_comb begin
    ex_d = '0;
    if (!bubble_ex && id_valid)
      ex_d = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, is_load: id_is_load};
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all slots advance together.
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      fl_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  // A single-cycle flush is fully covered by the redirect cycle, so FLUSH is skipped then.
  always_comb begin
    state_d  = state_q;
    fl_cnt_d = fl_cnt_q;
    if (ex_redirect) begin
      state_d  = (FLUSH_CYC > 1) ? FLUSH : IDLE;
      fl_cnt_d = (FLUSH_CYC > 1) ? 2'd1 : 2'd0;
    end else begin
      case (state_q)
        IDLE:  if (hazard) state_d = STALL;
        STALL: if (!hazard) state_d = IDLE;
        FLUSH: begin
          if (fl_cnt_q >= FLUSH_LAST) begin
            state_d  = IDLE;
            fl_cnt_d = 2'd0;
          end else begin
            fl_cnt_d = fl_cnt_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three parameterisations share one stimulus stream
// (default, stall-only, two-cycle flush with 2-bit counters).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
  logic [31:0] id_rdata1, id_rdata2, ex_fwd_data, mem_fwd_data, wb_fwd_data;
  logic        ex_redirect;

  logic        d_stall, d_flush, d_bubble, n_stall, n_flush, n_bubble, f_stall, f_flush, f_bubble;
  logic [1:0]  d_sel1, d_sel2, n_sel1, n_sel2, f_sel1, f_sel2;
  logic [31:0] d_rd1, d_rd2, n_rd1, n_rd2, f_rd1, f_rd2;
  logic [15:0] d_scnt, d_fcnt, n_scnt, n_fcnt;
  logic [1:0]  f_scnt, f_fcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_redirect(ex_redirect), .stall_if(d_stall), .flush_id(d_flush), .bubble_ex(d_bubble),
    .fwd_sel1(d_sel1), .fwd_sel2(d_sel2), .fwd_rdata1(d_rd1), .fwd_rdata2(d_rd2),
    .stall_cnt(d_scnt), .flush_cnt(d_fcnt)
  );

  hazard_ctrl #(.FWD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_redirect(ex_redirect), .stall_if(n_stall), .flush_id(n_flush), .bubble_ex(n_bubble),
    .fwd_sel1(n_sel1), .fwd_sel2(n_sel2), .fwd_rdata1(n_rd1), .fwd_rdata2(n_rd2),
    .stall_cnt(n_scnt), .flush_cnt(n_fcnt)
  );

  hazard_ctrl #(.FLUSH_CYC(2), .CNT_W(2)) u_f2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .ex_redirect(ex_redirect), .stall_if(f_stall), .flush_id(f_flush), .bubble_ex(f_bubble),
    .fwd_sel1(f_sel1), .fwd_sel2(f_sel2), .fwd_rdata1(f_rd1), .fwd_rdata2(f_rd2),
    .stall_cnt(f_scnt), .flush_cnt(f_fcnt)
  );

  typedef struct {
    logic [4:0] a_rd;
    logic       a_wr;
    logic       a_ld;
    int         gap;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [1:0] sel1;
    logic [1:0] sel2;
    logic       stall;
    logic       nf_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = wr; id_is_load = ld;
  endtask

  task automatic set_nop;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    ex_redirect = 1'b0;
    set_nop();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] exp_data(input logic [1:0] sel, input logic [31:0] rf);
    case (sel)
      2'd1:    return 32'h11;
      2'd2:    return 32'h22;
      2'd3:    return 32'h33;
      default: return rf;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    ex_fwd_data = 32'h11; mem_fwd_data = 32'h22; wb_fwd_data = 32'h33;
    id_rdata1 = 32'hA1; id_rdata2 = 32'hA2;
    rst = 1'b0; ex_redirect = 1'b0; set_nop();

    //          a_rd  wr    ld   gap rs1   rs2   u1    u2    sel1  sel2  stall nf_stall
    vecs[0] = '{5'd5, 1'b1, 1'b0, 0, 5'd5, 5'd1, 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1};
    vecs[1] = '{5'd5, 1'b1, 1'b1, 0, 5'd5, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1};
    vecs[2] = '{5'd7, 1'b1, 1'b0, 1, 5'd3, 5'd7, 1'b1, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1};
    vecs[3] = '{5'd9, 1'b1, 1'b0, 2, 5'd9, 5'd9, 1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 1'b1};
    vecs[4] = '{5'd9, 1'b1, 1'b0, 3, 5'd9, 5'd9, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[5] = '{5'd0, 1'b1, 1'b0, 0, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[6] = '{5'd5, 1'b1, 1'b0, 0, 5'd5, 5'd2, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[7] = '{5'd5, 1'b0, 1'b0, 0, 5'd5, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[8] = '{5'd4, 1'b1, 1'b1, 1, 5'd4, 5'd4, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b1};
    vecs[9] = '{5'd0, 1'b1, 1'b1, 0, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};

    do_reset();
    #1;
    check("reset_stall", d_stall, 1'b0);
    check("reset_flush", d_flush, 1'b0);
    check("reset_sel1", d_sel1, 2'd0);
    check("reset_rdata1", d_rd1, 32'hA1);
    check("reset_scnt", d_scnt, 16'd0);

    // Producer A, optional NOP gap, then consumer B; check B's operand resolution.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, vecs[i].a_rd, vecs[i].a_wr, vecs[i].a_ld);
      next_cycle();
      for (int g = 0; g < vecs[i].gap; g++) begin
        set_nop();
        next_cycle();
      end
      set_id(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, 5'd0, 1'b0, 1'b0);
      #1;
      check($sformatf("v%0d_sel1", i), d_sel1, vecs[i].sel1);
      check($sformatf("v%0d_sel2", i), d_sel2, vecs[i].sel2);
      check($sformatf("v%0d_rdata1", i), d_rd1, exp_data(vecs[i].sel1, 32'hA1));
      check($sformatf("v%0d_rdata2", i), d_rd2, exp_data(vecs[i].sel2, 32'hA2));
      check($sformatf("v%0d_stall", i), d_stall, vecs[i].stall);
      check($sformatf("v%0d_bubble", i), d_bubble, vecs[i].stall);
      check($sformatf("v%0d_nf_stall", i), n_stall, vecs[i].nf_stall);
      check($sformatf("v%0d_nf_sel1", i), n_sel1, 2'd0);
    end

    // Load-use: one stall cycle, then MEM forwarding.
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    check("lu_stall", d_stall, 1'b1);
    check("lu_bubble", d_bubble, 1'b1);
    next_cycle();
    #1;
    check("lu_stall_after", d_stall, 1'b0);
    check("lu_sel1", d_sel1, 2'd2);
    check("lu_rdata1", d_rd1, 32'h22);
    check("lu_sel2_x0", d_sel2, 2'd0);
    check("lu_scnt", d_scnt, 16'd1);
    set_nop();
    next_cycle();
    #1;
    check("lu_scnt_hold", d_scnt, 16'd1);

    // Stall-only variant: dependent instruction stalls until the producer leaves WB.
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (!n_stall) break;
      n++;
      next_cycle();
    end
    check("nf_stall_len", n, 3);
    check("nf_sel1_after", n_sel1, 2'd0);
    check("nf_rdata1_after", n_rd1, 32'hA1);
    check("nf_scnt", n_scnt, 16'd3);

    // Reset asserted mid-stall aborts at once; slots are empty afterwards.
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    #1;
    check("nf_midstall", n_stall, 1'b1);
    rst = 1'b0;
    #1;
    check("nf_rst_stall", n_stall, 1'b0);
    check("nf_rst_bubble", n_bubble, 1'b0);
    check("nf_rst_scnt", n_scnt, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("nf_post_rst_stall", n_stall, 1'b0);

    // Load-use and redirect together: redirect wins, two flush cycles on u_f2.
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    #1;
    check("rd_f2_stall", f_stall, 1'b0);
    check("rd_f2_flush", f_flush, 1'b1);
    check("rd_f2_bubble", f_bubble, 1'b1);
    check("rd_d_stall", d_stall, 1'b0);
    check("rd_d_flush", d_flush, 1'b1);
    next_cycle();
    ex_redirect = 1'b0;
    #1;
    check("rd_f2_flush_c1", f_flush, 1'b1);
    check("rd_f2_bubble_c1", f_bubble, 1'b1);
    check("rd_f2_stall_c1", f_stall, 1'b0);
    check("rd_d_flush_c1", d_flush, 1'b0);
    set_nop();
    next_cycle();
    #1;
    check("rd_f2_flush_c2", f_flush, 1'b0);
    check("rd_f2_fcnt", f_fcnt, 2'd1);
    check("rd_d_fcnt", d_fcnt, 16'd1);

    // Back-to-back redirects restart the flush count; counter saturates at 3.
    ex_redirect = 1'b1;
    #1;
    check("rs_flush_a", f_flush, 1'b1);
    next_cycle();
    #1;
    check("rs_flush_b", f_flush, 1'b1);
    next_cycle();
    ex_redirect = 1'b0;
    #1;
    check("rs_flush_c", f_flush, 1'b1);
    next_cycle();
    #1;
    check("rs_flush_d", f_flush, 1'b0);
    ex_redirect = 1'b1;
    next_cycle();
    ex_redirect = 1'b0;
    #1;
    check("rs_f2_fcnt_sat", f_fcnt, 2'd3);
    check("rs_d_fcnt", d_fcnt, 16'd4);
    check("rs_f2_in_flush", f_flush, 1'b1);

    // Reset pulse mid-FLUSH forces every output quiet asynchronously.
    rst = 1'b0;
    #1;
    check("rf_flush", f_flush, 1'b0);
    check("rf_stall", f_stall, 1'b0);
    check("rf_bubble", f_bubble, 1'b0);
    check("rf_sel1", f_sel1, 2'd0);
    check("rf_rdata1", f_rd1, 32'hA1);
    check("rf_fcnt", f_fcnt, 2'd0);
    check("rf_scnt", f_scnt, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rf_post_flush", f_flush, 1'b0);

    // Five load-use stalls: 2-bit counter saturates, 16-bit one counts them all.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
      next_cycle();
      set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      next_cycle();
    end
    #1;
    check("sat_f2_scnt", f_scnt, 2'd3);
    check("sat_d_scnt", d_scnt, 16'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
